// File: rtl/nn_pkg.sv
// rtl/nn_pkg.sv - shared widths, FSM encoding and saturation limits for the neuron datapath
package nn_pkg;

   localparam int PROD_W  = 26;
   localparam int N_TERMS = 784;
   localparam int CNT_W   = 10;
   localparam int ACC_W   = 36;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCUM  = 2'd1,
      FINISH = 2'd2
   } state_t;

   localparam logic [PROD_W-1:0] SAT_MAX = {1'b0, {(PROD_W-1){1'b1}}};
   localparam logic [PROD_W-1:0] SAT_MIN = {1'b1, {(PROD_W-1){1'b0}}};

endpackage

// File: rtl/sat_trunc.sv
// rtl/sat_trunc.sv - clamps a wide signed accumulator into PROD_W and flags overflow
module sat_trunc
   import nn_pkg::*;
#(
   parameter int IN_W = ACC_W
) (
   input  logic [IN_W-1:0]   acc,
   output logic [PROD_W-1:0] res,
   output logic              ovf
);

   // The value fits only when every bit from the output sign bit upward agrees.
   logic [IN_W-PROD_W:0] upper;

   assign upper = acc[IN_W-1:PROD_W-1];
   assign ovf   = ~((&upper) | ~(|upper));

   always_comb begin
      res = acc[PROD_W-1:0];
      if (ovf) begin
         res = acc[IN_W-1] ? SAT_MIN : SAT_MAX;
      end
   end

endmodule

// File: rtl/neuron_accumulator.sv
// rtl/neuron_accumulator.sv - sums N_TERMS signed products onto a bias and emits a saturated result
module neuron_accumulator #(
   parameter int PROD_W  = nn_pkg::PROD_W,
   parameter int N_TERMS = nn_pkg::N_TERMS,
   parameter int CNT_W   = nn_pkg::CNT_W,
   parameter int ACC_W   = nn_pkg::ACC_W
) (
   input  logic              clk,
   input  logic              GlobalReset,
   input  logic              start,
   input  logic [PROD_W-1:0] bias_in,
   input  logic [PROD_W-1:0] prod_in,
   input  logic              prod_valid,
   output logic              busy,
   output logic [PROD_W-1:0] out_data,
   output logic              out_valid,
   output logic              sat_flag
);

   import nn_pkg::*;

   localparam logic [CNT_W-1:0] LAST = CNT_W'(N_TERMS - 1);

   state_t             state;
   state_t             state_nxt;
   logic [ACC_W-1:0]   acc;
   logic [CNT_W-1:0]   count;
   logic [ACC_W-1:0]   bias_ext;
   logic [ACC_W-1:0]   prod_ext;
   logic [PROD_W-1:0]  sat_res;
   logic               sat_ovf;

   assign bias_ext = {{(ACC_W-PROD_W){bias_in[PROD_W-1]}}, bias_in};
   assign prod_ext = {{(ACC_W-PROD_W){prod_in[PROD_W-1]}}, prod_in};
   assign busy     = (state == ACCUM);

   sat_trunc #(
      .IN_W (ACC_W)
   ) u_sat (
      .acc (acc),
      .res (sat_res),
      .ovf (sat_ovf)
   );

   always_ff @(posedge clk or posedge GlobalReset) begin
      if (GlobalReset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // A start seen in ACCUM wins over the product on the same cycle.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (start) state_nxt = ACCUM;
         end
         ACCUM: begin
            if (!start && prod_valid && count == LAST) state_nxt = FINISH;
         end
         FINISH: begin
            state_nxt = start ? ACCUM : IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge GlobalReset) begin
      if (GlobalReset) begin
         acc       <= '0;
         count     <= '0;
         out_data  <= '0;
         out_valid <= 1'b0;
         sat_flag  <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         if (start) begin
            acc   <= bias_ext;
            count <= '0;
         end else if (state == ACCUM && prod_valid) begin
            acc   <= acc + prod_ext;
            count <= count + 1'b1;
         end
         if (state == FINISH) begin
            out_data  <= sat_res;
            sat_flag  <= sat_ovf;
            out_valid <= 1'b1;
         end
      end
   end

endmodule
